// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-size
// encodings and the alignment rule applied to incoming requests.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      STORE,
      LOAD_ADDR,
      LOAD_DATA,
      RESP
   } lsu_state_t;

   localparam logic [1:0] MODE_WORD = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b10;
   localparam logic [1:0] MODE_BYTE = 2'b11;

   // Modes 00 and 01 are both word accesses, so only mode[1] separates word from sub-word.
   function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      if (mode == MODE_HALF)
         bad = offset[0];
      else if (!mode[1])
         bad = (offset != 2'b00);
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_extract.sv
// Combinational lane select and sign/zero extension of a registered memory word
// for byte, halfword and word loads.
module load_extract
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  mode,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic zext);
      logic signed [7:0]  b_s;
      logic signed [31:0] wide_s;
      b_s    = b;
      wide_s = {{24{b_s[7]}}, b_s};
      return zext ? {24'h0, b} : wide_s;
   endfunction

   function automatic logic [31:0] extend_half(input logic [15:0] h, input logic zext);
      logic signed [15:0] h_s;
      logic signed [31:0] wide_s;
      h_s    = h;
      wide_s = {{16{h_s[15]}}, h_s};
      return zext ? {16'h0, h} : wide_s;
   endfunction

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      lane_byte = word[7:0];
      case (offset)
         2'b00:   lane_byte = word[7:0];
         2'b01:   lane_byte = word[15:8];
         2'b10:   lane_byte = word[23:16];
         default: lane_byte = word[31:24];
      endcase
      lane_half = offset[1] ? word[31:16] : word[15:0];

      result = word;
      if (mode == MODE_BYTE)
         result = extend_byte(lane_byte, is_unsigned);
      else if (mode == MODE_HALF)
         result = extend_half(lane_half, is_unsigned);
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store controller driving the write port and one read
// port of the byte-banked memory; rejects misaligned accesses without issuing them.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     clock_in,
   input  logic                     reset_in,
   input  logic                     req_in,
   input  logic                     we_in,
   input  logic [1:0]               memMode_in,
   input  logic                     unsigned_in,
   input  logic [ADDRESS_WIDTH-1:0] address_in,
   input  logic [31:0]              store_data_in,
   output logic                     ready_out,
   output logic                     done_out,
   output logic                     error_out,
   output logic [31:0]              load_data_out,
   output logic                     mem_write_out,
   output logic [1:0]               mem_memMode_out,
   output logic [ADDRESS_WIDTH-1:0] mem_write_address_out,
   output logic [31:0]              mem_write_data_out,
   output logic [ADDRESS_WIDTH-1:0] mem_read_address_out,
   output logic                     mem_read_en_out,
   input  logic [31:0]              mem_read_data_in
);

   lsu_state_t state, state_next;

   logic                     accept;
   logic                     misaligned;
   logic                     req_we_p1;
   logic [1:0]               req_mode_p1;
   logic                     req_unsigned_p1;
   logic [ADDRESS_WIDTH-1:0] req_addr_p1;
   logic [31:0]              req_data_p1;
   logic                     error_p2;
   logic [31:0]              load_data_p2;
   logic [31:0]              extracted;

   assign misaligned = is_misaligned(memMode_in, address_in[1:0]);

   always_ff @(posedge clock_in) begin
      if (reset_in)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next      = state;
      accept          = 1'b0;
      ready_out       = 1'b0;
      done_out        = 1'b0;
      mem_write_out   = 1'b0;
      mem_read_en_out = 1'b0;
      case (state)
         IDLE: begin
            ready_out = 1'b1;
            if (req_in) begin
               accept = 1'b1;
               if (misaligned)
                  state_next = RESP;
               else if (we_in)
                  state_next = STORE;
               else
                  state_next = LOAD_ADDR;
            end
         end
         STORE: begin
            mem_write_out = 1'b1;
            state_next    = RESP;
         end
         LOAD_ADDR: state_next = LOAD_DATA;
         LOAD_DATA: begin
            mem_read_en_out = 1'b1;
            state_next      = RESP;
         end
         RESP: begin
            done_out   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Stage p1: accepted request, held stable until the unit returns to IDLE
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         req_we_p1       <= 1'b0;
         req_mode_p1     <= 2'b00;
         req_unsigned_p1 <= 1'b0;
         req_addr_p1     <= '0;
         req_data_p1     <= 32'h0;
      end else if (accept) begin
         req_we_p1       <= we_in;
         req_mode_p1     <= memMode_in;
         req_unsigned_p1 <= unsigned_in;
         req_addr_p1     <= address_in;
         req_data_p1     <= store_data_in;
      end
   end

   assign mem_memMode_out       = req_mode_p1;
   assign mem_write_address_out = req_addr_p1;
   assign mem_write_data_out    = req_data_p1;
   assign mem_read_address_out  = req_addr_p1;

   load_extract u_extract (
      .word        (mem_read_data_in),
      .offset      (req_addr_p1[1:0]),
      .mode        (req_mode_p1),
      .is_unsigned (req_unsigned_p1),
      .result      (extracted)
   );

   // Stage p2: completion status and load result, updated on the edge entering RESP
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         error_p2     <= 1'b0;
         load_data_p2 <= 32'h0;
      end else begin
         if (accept && misaligned)
            error_p2 <= 1'b1;
         else if (state == STORE || state == LOAD_DATA)
            error_p2 <= 1'b0;
         if (state == LOAD_DATA && !req_we_p1)
            load_data_p2 <= extracted;
      end
   end

   assign error_out     = error_p2;
   assign load_data_out = load_data_p2;

endmodule
